multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Parametrised successor of the multicycle MIPS control unit.
- Sequences FETCH/DECODE/EXEC/MEM/WB for R-type (ADD, SUB, AND, XOR, NOP, BREAK), BEQ, BNE, LW, SW, LUI and J.
- Memory latency is configurable. Adds overflow/illegal-instruction exception and a BREAK halt.
- Drives every datapath mux select and register load in the multicycle datapath.

Parameters:
- MEM_WAIT, 2: extra cycles a memory access holds its address/data (0 = single-cycle memory).
- EXC_EN, 1: 1 = overflow and illegal opcode/funct trap to the exception vector; 0 = overflow ignored, illegal instruction treated as NOP.

Ports:
- Clk  in  1  clock.
- Reset  in  1  synchronous, active-high.
- Op  in  6  IR[31:26].
- Funct  in  6  IR[5:0].
- ALU_zero  in  1  ALU zero flag.
- ALU_overflow  in  1  ALU signed overflow.
- StateOut  out  8  current state encoding (debug).
- PC_load  out  1  PC write enable.
- PCSource  out  2  PC mux select: 00 ALU result, 01 ALUOut, 10 jump target, 11 exception vector.
- wr  out  1  memory write (1) / read (0).
- IorD  out  1  memory address select: 0 PC, 1 ALUOut.
- IR_load  out  1  IR write enable.
- MDR_load  out  1  MDR write enable.
- A_load  out  1  A register write enable.
- B_load  out  1  B register write enable.
- ALUOut_load  out  1  ALUOut write enable.
- RegWrite  out  1  register file write enable.
- RegDst  out  1  register file destination select: 0 rt, 1 rd.
- MemtoReg  out  2  register file write-data select: 00 ALUOut, 01 MDR, 10 {imm,16'b0}.
- ALUSrcA  out  1  ALU A select: 0 PC, 1 A.
- ALUSrcB  out  2  ALU B select: 00 B, 01 +4, 10 sext imm, 11 sext imm<<2.
- ALUOp  out  2  ALU operation: 00 add, 01 sub, 10 funct-decoded.
- Exception  out  1  one-cycle trap pulse.
- Halted  out  1  high while in HALT.

Behaviour:
- Moore outputs, combinational from state and wait counter. Only PC_load in BRANCH also depends on ALU_zero.
- Outputs not listed for a state: enables 0, selects 0.
- Reset (sync): state<=FETCH, cnt<=0. While Reset is high, all enables (PC_load, wr, IR/MDR/A/B/ALUOut_load, RegWrite, Exception) are forced 0.
- Reset mid-operation aborts the instruction; the first FETCH begins the cycle after Reset falls. Reset also exits HALT.
- Wait counter cnt (width $clog2(MEM_WAIT+1), min 1) applies to FETCH, LW_READ and SW_WRITE:
  - Each of these states lasts MEM_WAIT+1 cycles.
  - cnt increments each cycle and clears on exit.
  - "last" means cnt==MEM_WAIT.
- FETCH:
  - All cycles: IorD=0, wr=0.
  - Last cycle: IR_load=1; PC_load=1 with ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00 (PC+4). Then ->DECODE.
- DECODE: A_load=1, B_load=1, ALUOut_load=1 with ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target). Next state by Op:
  - 00 with Funct 20/22/24/26 -> R_EXEC.
  - 00 with Funct 00 -> FETCH.
  - 00 with Funct 0d -> HALT.
  - 04/05 -> BRANCH.
  - 23/2b -> MEM_ADDR.
  - 0f -> LUI_WB.
  - 02 -> JUMP.
  - Anything else -> EXC (EXC_EN=1) or FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10, ALUOut_load=1. If EXC_EN and ALU_overflow and Funct is 20 or 22 -> EXC (no writeback); else -> R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=00. ->FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01. PC_load = ALU_zero for Op 04, ~ALU_zero for Op 05. ->FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00, ALUOut_load=1. ->LW_READ (Op 23) or SW_WRITE (Op 2b).
- LW_READ: IorD=1, wr=0 all cycles; MDR_load=1 on last cycle. ->LW_WB.
- LW_WB: RegWrite=1, RegDst=0, MemtoReg=01. ->FETCH.
- SW_WRITE: IorD=1, wr=1 all cycles. ->FETCH after last.
- LUI_WB: RegWrite=1, RegDst=0, MemtoReg=10. ->FETCH.
- JUMP: PC_load=1, PCSource=10. ->FETCH.
- EXC: PC_load=1, PCSource=11, Exception=1. ->FETCH.
- HALT: Halted=1, all enables 0. Self-loop until Reset.
- Latency in cycles, W=MEM_WAIT:
  - R-type: W+4.
  - BEQ/BNE, J, LUI: W+3.
  - NOP: W+2.
  - LW: 2W+5.
  - SW: 2W+4.
  - Overflow trap: W+4.
- StateOut is registered and equals the current state encoding.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state_t enum (8-bit): FETCH=0, DECODE, R_EXEC, R_WB, BRANCH, MEM_ADDR, LW_READ, LW_WB, SW_WRITE, LUI_WB, JUMP, EXC, HALT.
  - Opcode and funct localparams.
  - ALUOp, ALUSrcB, PCSource and MemtoReg code constants.
- One sub-module, mem_wait_counter (params MEM_WAIT; ports Clk, Reset, clear, last), shared by FETCH/LW_READ/SW_WRITE.

Test Plan:
- MEM_WAIT=2, Reset held 2 cycles then released, Op=00 Funct=20, ALU_overflow=0:
  - IR_load and PC_load high only in cycle 3.
  - RegWrite=1, RegDst=1 in cycle 6.
  - StateOut back to 0 in cycle 7.
- LW (Op=23), MEM_WAIT=2:
  - wr=0, IorD=1 for 3 cycles.
  - MDR_load in the third of those cycles.
  - RegWrite with MemtoReg=01 at total cycle 9.
- SW (Op=2b), MEM_WAIT=0:
  - wr=1 for exactly 1 cycle, then FETCH.
  - Instruction totals 4 cycles.
- BEQ with ALU_zero=1 -> PC_load=1, PCSource=01. BNE with ALU_zero=1 -> PC_load=0.
- ADD with ALU_overflow=1 in R_EXEC -> no RegWrite; Exception=1 and PCSource=11 for one cycle; next state FETCH. Op=3f gives the same trap.
- BREAK (Funct=0d) -> Halted=1 indefinitely with all enables 0. Reset pulse -> FETCH.
- Reset asserted during LW_READ -> all enables 0 that cycle, state FETCH next, MDR_load never asserted.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared state encoding, opcode/funct values and datapath select codes for the
// multicycle MIPS control unit.
package mips_ctrl_pkg;

    typedef enum logic [7:0] {
        FETCH    = 8'd0,
        DECODE   = 8'd1,
        R_EXEC   = 8'd2,
        R_WB     = 8'd3,
        BRANCH   = 8'd4,
        MEM_ADDR = 8'd5,
        LW_READ  = 8'd6,
        LW_WB    = 8'd7,
        SW_WRITE = 8'd8,
        LUI_WB   = 8'd9,
        JUMP     = 8'd10,
        EXC      = 8'd11,
        HALT     = 8'd12
    } state_t;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpLui   = 6'h0f;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2b;

    localparam logic [5:0] FnNop   = 6'h00;
    localparam logic [5:0] FnBreak = 6'h0d;
    localparam logic [5:0] FnAdd   = 6'h20;
    localparam logic [5:0] FnSub   = 6'h22;
    localparam logic [5:0] FnAnd   = 6'h24;
    localparam logic [5:0] FnXor   = 6'h26;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    localparam logic [1:0] SrcBReg   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBImmSh = 2'b11;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;
    localparam logic [1:0] PcSrcExc    = 2'b11;

    localparam logic [1:0] MemtoRegAluOut = 2'b00;
    localparam logic [1:0] MemtoRegMdr    = 2'b01;
    localparam logic [1:0] MemtoRegLui    = 2'b10;

    function automatic logic is_alu_funct(logic [5:0] funct);
        return (funct == FnAdd) || (funct == FnSub) || (funct == FnAnd) || (funct == FnXor);
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Cycle counter that stretches a memory-facing state to MEM_WAIT+1 cycles.
module mem_wait_counter #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clear,
    output logic last
);

    localparam int unsigned CntW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge Clk) begin
        if (Reset || clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign last = (cnt_q == CntW'(MEM_WAIT));

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath with configurable memory
// latency, overflow/illegal-instruction trap and BREAK halt.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 2,
    parameter bit          EXC_EN   = 1'b1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       ALU_zero,
    input  logic       ALU_overflow,
    output logic [7:0] StateOut,
    output logic       PC_load,
    output logic [1:0] PCSource,
    output logic       wr,
    output logic       IorD,
    output logic       IR_load,
    output logic       MDR_load,
    output logic       A_load,
    output logic       B_load,
    output logic       ALUOut_load,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       Exception,
    output logic       Halted
);

    state_t state_q, state_d;
    logic   last, wait_state, clear;

    // The counter runs only inside memory-facing states and restarts on exit.
    assign wait_state = (state_q == FETCH) || (state_q == LW_READ) || (state_q == SW_WRITE);
    assign clear      = !wait_state || last;

    mem_wait_counter #(
        .MEM_WAIT(MEM_WAIT)
    ) u_wait (
        .Clk  (Clk),
        .Reset(Reset),
        .clear(clear),
        .last (last)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign StateOut = state_q;

    always_comb begin
        state_d     = state_q;
        PC_load     = 1'b0;
        PCSource    = PcSrcAlu;
        wr          = 1'b0;
        IorD        = 1'b0;
        IR_load     = 1'b0;
        MDR_load    = 1'b0;
        A_load      = 1'b0;
        B_load      = 1'b0;
        ALUOut_load = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = MemtoRegAluOut;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SrcBReg;
        ALUOp       = AluOpAdd;
        Exception   = 1'b0;
        Halted      = 1'b0;

        case (state_q)
            FETCH: begin
                if (last) begin
                    IR_load = 1'b1;
                    PC_load = 1'b1;
                    ALUSrcB = SrcBFour;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                A_load      = 1'b1;
                B_load      = 1'b1;
                ALUOut_load = 1'b1;
                ALUSrcB     = SrcBImmSh;
                case (Op)
                    OpRtype: begin
                        if (is_alu_funct(Funct)) begin
                            state_d = R_EXEC;
                        end else if (Funct == FnNop) begin
                            state_d = FETCH;
                        end else if (Funct == FnBreak) begin
                            state_d = HALT;
                        end else begin
                            state_d = EXC_EN ? EXC : FETCH;
                        end
                    end
                    OpBeq, OpBne: state_d = BRANCH;
                    OpLw, OpSw:   state_d = MEM_ADDR;
                    OpLui:        state_d = LUI_WB;
                    OpJ:          state_d = JUMP;
                    default:      state_d = EXC_EN ? EXC : FETCH;
                endcase
            end
            R_EXEC: begin
                ALUSrcA     = 1'b1;
                ALUOp       = AluOpFunct;
                ALUOut_load = 1'b1;
                if (EXC_EN && ALU_overflow && ((Funct == FnAdd) || (Funct == FnSub))) begin
                    state_d = EXC;
                end else begin
                    state_d = R_WB;
                end
            end
            R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                state_d  = FETCH;
            end
            BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = AluOpSub;
                PCSource = PcSrcAluOut;
                PC_load  = (Op == OpBeq) ? ALU_zero : !ALU_zero;
                state_d  = FETCH;
            end
            MEM_ADDR: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SrcBImm;
                ALUOut_load = 1'b1;
                state_d     = (Op == OpLw) ? LW_READ : SW_WRITE;
            end
            LW_READ: begin
                IorD = 1'b1;
                if (last) begin
                    MDR_load = 1'b1;
                    state_d  = LW_WB;
                end
            end
            LW_WB: begin
                RegWrite = 1'b1;
                MemtoReg = MemtoRegMdr;
                state_d  = FETCH;
            end
            SW_WRITE: begin
                IorD = 1'b1;
                wr   = 1'b1;
                if (last) begin
                    state_d = FETCH;
                end
            end
            LUI_WB: begin
                RegWrite = 1'b1;
                MemtoReg = MemtoRegLui;
                state_d  = FETCH;
            end
            JUMP: begin
                PC_load  = 1'b1;
                PCSource = PcSrcJump;
                state_d  = FETCH;
            end
            EXC: begin
                PC_load   = 1'b1;
                PCSource  = PcSrcExc;
                Exception = 1'b1;
                state_d   = FETCH;
            end
            HALT: begin
                Halted = 1'b1;
            end
            default: state_d = FETCH;
        endcase

        // Reset aborts whatever is in flight, so no side effect may leak out.
        if (Reset) begin
            PC_load     = 1'b0;
            wr          = 1'b0;
            IR_load     = 1'b0;
            MDR_load    = 1'b0;
            A_load      = 1'b0;
            B_load      = 1'b0;
            ALUOut_load = 1'b0;
            RegWrite    = 1'b0;
            Exception   = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: table-driven and random instructions on two control units
// (MEM_WAIT=2 with traps, MEM_WAIT=0 without) against a per-instruction trace model.
module tb_multicycle_control;

    typedef struct packed {
        logic [7:0] state;
        logic       pc_load;
        logic [1:0] pc_src;
        logic       wr;
        logic       iord;
        logic       ir_load;
        logic       mdr_load;
        logic       a_load;
        logic       b_load;
        logic       aluout_load;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       exc;
        logic       halted;
    } out_t;

    typedef struct {
        string      name;
        int         dut;
        logic [5:0] op;
        logic [5:0] fn;
        bit         zero;
        bit         ovf;
        int         lat;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst        [2];
    logic [5:0] op         [2];
    logic [5:0] fn         [2];
    logic       zero       [2];
    logic       ovf        [2];
    logic [7:0] so         [2];
    logic       pc_load    [2];
    logic [1:0] pc_src     [2];
    logic       wr         [2];
    logic       iord       [2];
    logic       ir_load    [2];
    logic       mdr_load   [2];
    logic       a_load     [2];
    logic       b_load     [2];
    logic       aluout_load[2];
    logic       reg_write  [2];
    logic       reg_dst    [2];
    logic [1:0] mem_to_reg [2];
    logic       alu_src_a  [2];
    logic [1:0] alu_src_b  [2];
    logic [1:0] alu_op     [2];
    logic       exc        [2];
    logic       halted     [2];

    int   vectors    = 0;
    int   miscompares = 0;
    out_t exp_q[$];
    vec_t tbl[$];
    bit   watch_mdr  = 1'b0;
    int   mdr_hits   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        multicycle_control #(
            .MEM_WAIT((g == 0) ? 2 : 0),
            .EXC_EN  (g == 0)
        ) u_dut (
            .Clk         (clk),
            .Reset       (rst[g]),
            .Op          (op[g]),
            .Funct       (fn[g]),
            .ALU_zero    (zero[g]),
            .ALU_overflow(ovf[g]),
            .StateOut    (so[g]),
            .PC_load     (pc_load[g]),
            .PCSource    (pc_src[g]),
            .wr          (wr[g]),
            .IorD        (iord[g]),
            .IR_load     (ir_load[g]),
            .MDR_load    (mdr_load[g]),
            .A_load      (a_load[g]),
            .B_load      (b_load[g]),
            .ALUOut_load (aluout_load[g]),
            .RegWrite    (reg_write[g]),
            .RegDst      (reg_dst[g]),
            .MemtoReg    (mem_to_reg[g]),
            .ALUSrcA     (alu_src_a[g]),
            .ALUSrcB     (alu_src_b[g]),
            .ALUOp       (alu_op[g]),
            .Exception   (exc[g]),
            .Halted      (halted[g])
        );
    end

    always @(posedge clk) if (watch_mdr && mdr_load[0] === 1'b1) mdr_hits++;

    function automatic int wv(int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic bit ev(int d);
        return d == 0;
    endfunction

    function automatic out_t actual(int d);
        out_t a;
        a.state = so[d];              a.pc_load = pc_load[d];     a.pc_src = pc_src[d];
        a.wr = wr[d];                 a.iord = iord[d];           a.ir_load = ir_load[d];
        a.mdr_load = mdr_load[d];     a.a_load = a_load[d];       a.b_load = b_load[d];
        a.aluout_load = aluout_load[d]; a.reg_write = reg_write[d]; a.reg_dst = reg_dst[d];
        a.mem_to_reg = mem_to_reg[d]; a.alu_src_a = alu_src_a[d]; a.alu_src_b = alu_src_b[d];
        a.alu_op = alu_op[d];         a.exc = exc[d];             a.halted = halted[d];
        return a;
    endfunction

    function automatic out_t blank(int st);
        out_t r = '0;
        r.state = 8'(st);
        return r;
    endfunction

    function automatic out_t mask_en(out_t r);
        out_t m = r;
        m.pc_load = 0; m.wr = 0; m.ir_load = 0; m.mdr_load = 0; m.a_load = 0;
        m.b_load = 0; m.aluout_load = 0; m.reg_write = 0; m.exc = 0;
        return m;
    endfunction

    function automatic out_t fetch_rec(int k, int w);
        out_t r = blank(0);
        if (k == w) begin
            r.ir_load = 1; r.pc_load = 1; r.alu_src_b = 2'b01;
        end
        return r;
    endfunction

    // Expected cycle-by-cycle trace of one instruction, from FETCH to its last state.
    function automatic void build(int w, bit exc_en, logic [5:0] o, logic [5:0] f, bit z, bit v);
        out_t r;
        bit alu_fn = (f == 6'h20) || (f == 6'h22) || (f == 6'h24) || (f == 6'h26);
        out_t trap = blank(11);
        trap.pc_load = 1; trap.pc_src = 2'b11; trap.exc = 1;
        for (int k = 0; k <= w; k++) exp_q.push_back(fetch_rec(k, w));
        r = blank(1); r.a_load = 1; r.b_load = 1; r.aluout_load = 1; r.alu_src_b = 2'b11;
        exp_q.push_back(r);
        if (o == 6'h00 && alu_fn) begin
            r = blank(2); r.alu_src_a = 1; r.alu_op = 2'b10; r.aluout_load = 1;
            exp_q.push_back(r);
            if (exc_en && v && (f == 6'h20 || f == 6'h22)) exp_q.push_back(trap);
            else begin
                r = blank(3); r.reg_write = 1; r.reg_dst = 1; exp_q.push_back(r);
            end
        end else if (o == 6'h00 && f == 6'h00) begin
        end else if (o == 6'h00 && f == 6'h0d) begin
            r = blank(12); r.halted = 1;
            repeat (4) exp_q.push_back(r);
        end else if (o == 6'h04 || o == 6'h05) begin
            r = blank(4); r.alu_src_a = 1; r.alu_op = 2'b01; r.pc_src = 2'b01;
            r.pc_load = (o == 6'h04) ? z : !z;
            exp_q.push_back(r);
        end else if (o == 6'h23 || o == 6'h2b) begin
            r = blank(5); r.alu_src_a = 1; r.alu_src_b = 2'b10; r.aluout_load = 1;
            exp_q.push_back(r);
            for (int k = 0; k <= w; k++) begin
                if (o == 6'h23) begin
                    r = blank(6); r.iord = 1; r.mdr_load = (k == w);
                end else begin
                    r = blank(8); r.iord = 1; r.wr = 1;
                end
                exp_q.push_back(r);
            end
            if (o == 6'h23) begin
                r = blank(7); r.reg_write = 1; r.mem_to_reg = 2'b01; exp_q.push_back(r);
            end
        end else if (o == 6'h0f) begin
            r = blank(9); r.reg_write = 1; r.mem_to_reg = 2'b10; exp_q.push_back(r);
        end else if (o == 6'h02) begin
            r = blank(10); r.pc_load = 1; r.pc_src = 2'b10; exp_q.push_back(r);
        end else if (exc_en) begin
            exp_q.push_back(trap);
        end
    endfunction

    task automatic check(string name, out_t act, out_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // reset_at: -1 none, -2 last trace cycle, else trace index at which Reset rises.
    task automatic run(int d, string name, logic [5:0] o, logic [5:0] f, bit z, bit v,
                       int lat, int reset_at);
        int   st_hist[$];
        int   ra;
        int   meas = -1;
        out_t a;
        op[d] = o; fn[d] = f; zero[d] = z; ovf[d] = v;
        exp_q.delete();
        build(wv(d), ev(d), o, f, z, v);
        ra = (reset_at == -2) ? exp_q.size() - 1 : reset_at;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == ra) rst[d] = 1'b1;
            #1;
            a = actual(d);
            st_hist.push_back(int'(a.state));
            if (i == ra) begin
                check({name, " reset"}, a, mask_en(exp_q[i]));
                @(posedge clk);
                #1 rst[d] = 1'b0;
                #1 check({name, " abort"}, actual(d), fetch_rec(0, wv(d)));
                return;
            end
            check(name, a, exp_q[i]);
            @(posedge clk);
            #1;
        end
        #1;
        a = actual(d);
        st_hist.push_back(int'(a.state));
        check({name, " next"}, a, fetch_rec(0, wv(d)));
        if (lat > 0) begin
            for (int i = 1; i < st_hist.size(); i++)
                if (meas < 0 && st_hist[i] == 0 && st_hist[i-1] != 0) meas = i;
            check_int({name, " latency"}, meas, lat);
        end
    endtask

    function automatic vec_t mk(string n, int d, logic [5:0] o, logic [5:0] f, bit z, bit v,
                                int lat);
        vec_t t;
        t.name = n; t.dut = d; t.op = o; t.fn = f; t.zero = z; t.ovf = v; t.lat = lat;
        return t;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [11:0] pool[14];
        pool = '{12'h020, 12'h022, 12'h024, 12'h026, 12'h000, 12'h100, 12'h140,
                 12'h8c0, 12'hac0, 12'h3c0, 12'h080, 12'hfc0, 12'h040, 12'h021};

        tbl.push_back(mk("add",      0, 6'h00, 6'h20, 0, 0, 6));
        tbl.push_back(mk("sub",      0, 6'h00, 6'h22, 1, 0, 6));
        tbl.push_back(mk("and_ovf",  0, 6'h00, 6'h24, 0, 1, 6));
        tbl.push_back(mk("xor",      0, 6'h00, 6'h26, 0, 0, 6));
        tbl.push_back(mk("nop",      0, 6'h00, 6'h00, 0, 0, 4));
        tbl.push_back(mk("beq_t",    0, 6'h04, 6'h11, 1, 0, 5));
        tbl.push_back(mk("beq_nt",   0, 6'h04, 6'h11, 0, 0, 5));
        tbl.push_back(mk("bne_z",    0, 6'h05, 6'h00, 1, 0, 5));
        tbl.push_back(mk("bne_nz",   0, 6'h05, 6'h00, 0, 0, 5));
        tbl.push_back(mk("lw",       0, 6'h23, 6'h04, 0, 0, 9));
        tbl.push_back(mk("sw",       0, 6'h2b, 6'h08, 0, 0, 8));
        tbl.push_back(mk("lui",      0, 6'h0f, 6'h00, 0, 0, 5));
        tbl.push_back(mk("j",        0, 6'h02, 6'h3f, 0, 0, 5));
        tbl.push_back(mk("add_ovf",  0, 6'h00, 6'h20, 0, 1, 6));
        tbl.push_back(mk("sub_ovf",  0, 6'h00, 6'h22, 0, 1, 6));
        tbl.push_back(mk("ill_op",   0, 6'h3f, 6'h00, 0, 0, 5));
        tbl.push_back(mk("ill_fn",   0, 6'h00, 6'h3f, 0, 0, 5));
        tbl.push_back(mk("w0_sw",    1, 6'h2b, 6'h00, 0, 0, 4));
        tbl.push_back(mk("w0_lw",    1, 6'h23, 6'h00, 0, 0, 5));
        tbl.push_back(mk("w0_add",   1, 6'h00, 6'h20, 0, 0, 4));
        tbl.push_back(mk("w0_ovfoff",1, 6'h00, 6'h20, 0, 1, 4));
        tbl.push_back(mk("w0_ill",   1, 6'h3f, 6'h00, 0, 0, 2));
        tbl.push_back(mk("w0_beq",   1, 6'h04, 6'h00, 1, 0, 3));
        tbl.push_back(mk("w0_nop",   1, 6'h00, 6'h00, 0, 0, 2));

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; op[d] = '0; fn[d] = '0; zero[d] = 1'b0; ovf[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) check("reset", actual(d), mask_en(fetch_rec(0, wv(d))));
        rst[0] = 1'b0;

        foreach (tbl[i])
            if (tbl[i].dut == 0)
                run(0, tbl[i].name, tbl[i].op, tbl[i].fn, tbl[i].zero, tbl[i].ovf, tbl[i].lat, -1);

        // Reset in the last LW_READ cycle must suppress MDR_load and restart at FETCH.
        watch_mdr = 1'b1;
        run(0, "lw_abort", 6'h23, 6'h00, 0, 0, 0, 7);
        watch_mdr = 1'b0;
        check_int("lw_abort mdr", mdr_hits, 0);

        run(0, "break", 6'h00, 6'h0d, 0, 0, 0, -2);
        run(0, "after_halt", 6'h00, 6'h20, 0, 0, 6, -1);

        for (int n = 0; n < 60; n++) begin
            int k = $urandom_range(13, 0);
            run(0, "rand_w2", pool[k][11:6], pool[k][5:0], 1'($urandom), 1'($urandom), 0, -1);
        end

        rst[0] = 1'b1;
        rst[1] = 1'b0;
        foreach (tbl[i])
            if (tbl[i].dut == 1)
                run(1, tbl[i].name, tbl[i].op, tbl[i].fn, tbl[i].zero, tbl[i].ovf, tbl[i].lat, -1);

        for (int n = 0; n < 30; n++) begin
            int k = $urandom_range(13, 0);
            run(1, "rand_w0", pool[k][11:6], pool[k][5:0], 1'($urandom), 1'($urandom), 0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
